// File: rtl/tree_build_ctrl.sv
// -----------------------------------------------------------------------------
// tree_build_ctrl
//
// Top-level sequencer for building a Huffman tree from code lengths. It owns
// the single-port code-length RAM. A run clears the RAM, streams lengths in
// from the header loader, then releases make_tree from reset and hands it the
// RAM port. The block reports done or error and puts a watchdog on the build
// phase. A low-priority debug read port can use the RAM while the block is
// not running.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start, abort        one-cycle control pulses; abort wins over start
//   num_codes           number of lengths to load, sampled with start
//   ld_valid/ld_ready   loader handshake; ld_data = {len, index}
//   tree_reset          active-high reset to make_tree
//   tree_len_*          make_tree RAM request (address, enable, write enable)
//   tree_sig_end        make_tree finished
//   tree_error          make_tree length error
//   dbg_req/dbg_addr    debug read request; dbg_gnt = granted this cycle
//   ram_*               code-length RAM port
//   busy/done/error     status; err_code: 1 bad num_codes, 2 tree_error,
//                       3 timeout
// -----------------------------------------------------------------------------
module tree_build_ctrl #(
  parameter int INDEX_BIT      = 5,
  parameter int LEN_BIT        = 3,
  parameter int LEN_ADDRESS    = 5,
  parameter int INDEX_COUNT    = 19,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [LEN_ADDRESS-1:0]       num_codes,
  input  logic                         ld_valid,
  input  logic [LEN_BIT+INDEX_BIT-1:0] ld_data,
  output logic                         ld_ready,
  output logic                         tree_reset,
  input  logic [LEN_ADDRESS-1:0]       tree_len_address,
  input  logic                         tree_len_ena,
  input  logic                         tree_len_wea,
  input  logic                         tree_sig_end,
  input  logic                         tree_error,
  input  logic                         dbg_req,
  input  logic [LEN_ADDRESS-1:0]       dbg_addr,
  output logic                         dbg_gnt,
  output logic [LEN_ADDRESS-1:0]       ram_addr,
  output logic                         ram_ena,
  output logic                         ram_wea,
  output logic [LEN_BIT+INDEX_BIT-1:0] ram_din,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code
);

  localparam int WORD_BIT = LEN_BIT + INDEX_BIT;

  // One-hot state encoding.
  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_CLEAR = 6'b000010;
  localparam logic [5:0] S_LOAD  = 6'b000100;
  localparam logic [5:0] S_BUILD = 6'b001000;
  localparam logic [5:0] S_DONE  = 6'b010000;
  localparam logic [5:0] S_FAIL  = 6'b100000;

  localparam logic [LEN_ADDRESS-1:0] LAST_INDEX = LEN_ADDRESS'(INDEX_COUNT - 1);
  localparam logic [LEN_ADDRESS-1:0] MAX_CODES  = LEN_ADDRESS'(INDEX_COUNT);
  localparam logic [15:0]            TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NUM     = 2'd1;
  localparam logic [1:0] ERR_TREE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  logic [5:0]             state, state_d;
  logic [LEN_ADDRESS-1:0] cnt, cnt_d;       // clear address / load word index
  logic [LEN_ADDRESS-1:0] num_q, num_d;     // latched num_codes
  logic [15:0]            tmo_cnt, tmo_d;   // build-phase watchdog
  logic [1:0]             err_q, err_d;

  logic in_idle, in_clear, in_load, in_build, in_done, in_fail;
  logic start_ok;

  assign in_idle  = (state == S_IDLE);
  assign in_clear = (state == S_CLEAR);
  assign in_load  = (state == S_LOAD);
  assign in_build = (state == S_BUILD);
  assign in_done  = (state == S_DONE);
  assign in_fail  = (state == S_FAIL);

  assign start_ok = (num_codes != '0) && (num_codes <= MAX_CODES);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state;
    cnt_d   = cnt;
    num_d   = num_q;
    tmo_d   = tmo_cnt;
    err_d   = err_q;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      err_d   = ERR_NONE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            if (start_ok) begin
              state_d = S_CLEAR;
              num_d   = num_codes;
              cnt_d   = '0;
              tmo_d   = '0;
              err_d   = ERR_NONE;
            end else begin
              state_d = S_FAIL;
              err_d   = ERR_NUM;
            end
          end
        end

        S_CLEAR: begin
          if (cnt == LAST_INDEX) begin
            state_d = S_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end

        S_LOAD: begin
          // ld_ready is constantly high in LOAD, so ld_valid is the handshake.
          if (ld_valid) begin
            if (cnt == num_q - 1'b1) begin
              state_d = S_BUILD;
              cnt_d   = '0;
              tmo_d   = '0;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end

        S_BUILD: begin
          tmo_d = tmo_cnt + 1'b1;
          if (tree_error) begin
            state_d = S_FAIL;
            err_d   = ERR_TREE;
          end else if (tree_sig_end) begin
            state_d = S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            state_d = S_FAIL;
            err_d   = ERR_TIMEOUT;
          end
        end

        default: begin
          // Illegal one-hot pattern: recover to IDLE.
          state_d = S_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = ERR_NONE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      num_q   <= '0;
      tmo_cnt <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      num_q   <= num_d;
      tmo_cnt <= tmo_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign busy       = in_clear | in_load | in_build;
  assign done       = in_done;
  assign error      = in_fail;
  assign err_code   = err_q;
  assign ld_ready   = in_load;
  // make_tree runs in BUILD and is kept out of reset in DONE so its results
  // remain readable.
  assign tree_reset = ~(in_build | in_done);

  // Debug reads only when no phase owns the RAM. Gating with reset keeps the
  // grant low while reset is asserted.
  assign dbg_gnt = reset & dbg_req & (in_idle | in_done | in_fail);

  // ---------------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr = '0;
    ram_ena  = 1'b0;
    ram_wea  = 1'b0;
    ram_din  = '0;

    if (dbg_gnt) begin
      ram_addr = dbg_addr;
      ram_ena  = 1'b1;
    end else if (in_clear) begin
      // Each entry is cleared to length 0 with its own address as the index.
      ram_addr = cnt;
      ram_ena  = 1'b1;
      ram_wea  = 1'b1;
      ram_din  = {{LEN_BIT{1'b0}}, INDEX_BIT'(cnt)};
    end else if (in_load) begin
      if (ld_valid) begin
        ram_addr = cnt;
        ram_ena  = 1'b1;
        ram_wea  = 1'b1;
        ram_din  = WORD_BIT'(ld_data);
      end
    end else if (in_build) begin
      ram_addr = tree_len_address;
      ram_ena  = tree_len_ena;
      ram_wea  = tree_len_wea;
    end
  end

endmodule

// File: tb/tb_tree_build_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tree_build_ctrl
//
// Directed bench for tree_build_ctrl. A table of complete runs (num_codes,
// loader gap pattern, make_tree ending) is applied by one task that checks
// every phase cycle by cycle, followed by hand-written sequences for reset in
// the middle of LOAD, abort and the debug read port.
// -----------------------------------------------------------------------------
module tb_tree_build_ctrl;

  localparam int IB  = 5;
  localparam int LB  = 3;
  localparam int LA  = 5;
  localparam int IC  = 19;
  localparam int TMO = 16;

  localparam int M_END = 0;  // tree_sig_end alone at end_at
  localparam int M_ERR = 1;  // tree_error and tree_sig_end together at end_at
  localparam int M_TMO = 2;  // make_tree never finishes

  logic          clock = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [LA-1:0] num_codes;
  logic          ld_valid;
  logic [LB+IB-1:0] ld_data;
  logic          ld_ready;
  logic          tree_reset;
  logic [LA-1:0] tree_len_address;
  logic          tree_len_ena, tree_len_wea, tree_sig_end, tree_error;
  logic          dbg_req;
  logic [LA-1:0] dbg_addr;
  logic          dbg_gnt;
  logic [LA-1:0] ram_addr;
  logic          ram_ena, ram_wea;
  logic [LB+IB-1:0] ram_din;
  logic          busy, done, error;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tree_build_ctrl #(
    .INDEX_BIT      (IB),
    .LEN_BIT        (LB),
    .LEN_ADDRESS    (LA),
    .INDEX_COUNT    (IC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .num_codes        (num_codes),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_ready         (ld_ready),
    .tree_reset       (tree_reset),
    .tree_len_address (tree_len_address),
    .tree_len_ena     (tree_len_ena),
    .tree_len_wea     (tree_len_wea),
    .tree_sig_end     (tree_sig_end),
    .tree_error       (tree_error),
    .dbg_req          (dbg_req),
    .dbg_addr         (dbg_addr),
    .dbg_gnt          (dbg_gnt),
    .ram_addr         (ram_addr),
    .ram_ena          (ram_ena),
    .ram_wea          (ram_wea),
    .ram_din          (ram_din),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_code         (err_code)
  );

  typedef struct {
    logic [LA-1:0] n;
    bit            gap;
    int            mode;
    int            end_at;
    int            exp_cycles;  // cycles spent in BUILD
    bit            exp_done;
    bit            exp_err;
    logic [1:0]    exp_code;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete run starting from IDLE, DONE or FAIL.
  task automatic run(input vec_t v);
    int bad;
    int acc;
    int t;
    int c;
    logic [LB+IB-1:0] w;

    @(posedge clock); #1;
    start     = 1'b1;
    num_codes = v.n;
    @(negedge clock);
    check("start_cycle_gnt", dbg_gnt, dbg_req);
    @(posedge clock); #1;
    start = 1'b0;

    if (v.exp_code == 2'd1) begin
      @(negedge clock);
      check("bad_num_fail", {error, err_code, busy, ram_ena, ram_wea},
            {1'b1, 2'd1, 1'b0, dbg_req, 1'b0});
      return;
    end

    // CLEAR: one write per cycle, addr 0..IC-1, din = {0, addr}
    bad = 0;
    for (int i = 0; i < IC; i++) begin
      @(negedge clock);
      if (!(busy && tree_reset && ram_ena && ram_wea && ram_addr == LA'(i) &&
            ram_din == {3'b000, 5'(i)} && !ld_ready && !dbg_gnt &&
            err_code == 2'd0 && !done && !error))
        bad++;
      @(posedge clock); #1;
    end
    check("clear_cycles", bad, 0);

    // LOAD
    acc = 0;
    t   = 0;
    bad = 0;
    while (acc < int'(v.n) && t < 100) begin
      ld_valid = v.gap ? ~t[0] : 1'b1;
      w        = {3'(acc + 1), 5'(acc * 3 + 2)};
      ld_data  = w;
      @(negedge clock);
      if (!ld_ready || !busy || !tree_reset || dbg_gnt) bad++;
      if (ld_valid) begin
        if (!(ram_ena && ram_wea && ram_addr == LA'(acc) && ram_din == w)) bad++;
        acc++;
      end else if (ram_ena) begin
        bad++;
      end
      @(posedge clock); #1;
      t++;
    end
    check("load_accepts", acc, int'(v.n));
    check("load_cycles", t, v.gap ? 2 * int'(v.n) - 1 : int'(v.n));
    check("load_writes", bad, 0);

    // BUILD: ld_valid stays high to show no extra word is taken.
    ld_valid = 1'b1;
    c   = 0;
    bad = 0;
    do begin
      tree_len_address = LA'(c * 3 + 1);
      tree_len_ena     = c[0];
      tree_len_wea     = c[1];
      tree_sig_end     = (v.mode != M_TMO) && (c == v.end_at);
      tree_error       = (v.mode == M_ERR) && (c == v.end_at);
      @(negedge clock);
      if (!(busy && !tree_reset && !ld_ready && !dbg_gnt &&
            ram_addr == tree_len_address && ram_ena == tree_len_ena &&
            ram_wea == tree_len_wea && ram_din == '0))
        bad++;
      @(posedge clock); #1;
      c++;
    end while (busy && c < 200);
    ld_valid     = 1'b0;
    tree_len_ena = 1'b0;
    tree_len_wea = 1'b0;
    tree_sig_end = 1'b0;
    tree_error   = 1'b0;
    check("build_mux", bad, 0);
    check("build_cycles", c, v.exp_cycles);

    @(negedge clock);
    check("outcome", {done, error, err_code, busy, ld_ready, tree_reset},
          {v.exp_done, v.exp_err, v.exp_code, 1'b0, 1'b0, ~v.exp_done});
    if (dbg_req)
      check("end_dbg_read", {dbg_gnt, ram_ena, ram_wea, ram_addr},
            {1'b1, 1'b1, 1'b0, dbg_addr});
    else
      check("end_ram_idle", {ram_ena, ram_wea}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    vec_t dv;

    vecs[0] = '{5'd4,  1'b0, M_END, 10, 11, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{5'd4,  1'b1, M_END,  3,  4, 1'b1, 1'b0, 2'd0};
    vecs[2] = '{5'd0,  1'b0, M_END,  0,  0, 1'b0, 1'b1, 2'd1};
    vecs[3] = '{5'd20, 1'b0, M_END,  0,  0, 1'b0, 1'b1, 2'd1};
    vecs[4] = '{5'd19, 1'b0, M_TMO,  0, 16, 1'b0, 1'b1, 2'd3};
    vecs[5] = '{5'd1,  1'b0, M_ERR,  5,  6, 1'b0, 1'b1, 2'd2};
    vecs[6] = '{5'd7,  1'b1, M_END,  0,  1, 1'b1, 1'b0, 2'd0};

    reset            = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    num_codes        = '0;
    ld_valid         = 1'b0;
    ld_data          = '0;
    tree_len_address = '0;
    tree_len_ena     = 1'b0;
    tree_len_wea     = 1'b0;
    tree_sig_end     = 1'b0;
    tree_error       = 1'b0;
    dbg_req          = 1'b0;
    dbg_addr         = '0;

    // Reset state
    #12;
    check("reset_outputs",
          {tree_reset, ram_addr, ram_ena, ram_wea, ram_din, ld_ready, dbg_gnt,
           busy, done, error, err_code},
          {1'b1, 22'd0});
    @(posedge clock); #1;
    reset = 1'b1;

    // Table of full runs
    for (int k = 0; k < 7; k++) run(vecs[k]);

    // abort beats start (block is in DONE after the last vector)
    @(posedge clock); #1;
    abort     = 1'b1;
    start     = 1'b1;
    num_codes = 5'd4;
    @(posedge clock); #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("abort_over_start", {busy, done, error, tree_reset, err_code}, {4'b0001, 2'd0});

    // Bad start into FAIL, then abort back to IDLE clears err_code
    @(posedge clock); #1;
    start     = 1'b1;
    num_codes = 5'd20;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("fail_err1", {error, err_code, ram_ena}, {1'b1, 2'd1, 1'b0});
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_from_fail", {error, done, busy, err_code, tree_reset}, {3'b000, 2'd0, 1'b1});

    // Debug port held across a full run
    dbg_req  = 1'b1;
    dbg_addr = 5'd9;
    @(negedge clock);
    check("dbg_idle", {dbg_gnt, ram_ena, ram_wea, ram_addr}, {1'b1, 1'b1, 1'b0, 5'd9});
    dv = '{5'd2, 1'b0, M_END, 2, 3, 1'b1, 1'b0, 2'd0};
    run(dv);
    dbg_req = 1'b0;
    @(negedge clock);
    check("dbg_released", {dbg_gnt, ram_ena}, 2'b00);

    // Reset in the middle of LOAD after three accepted words
    @(posedge clock); #1;
    start     = 1'b1;
    num_codes = 5'd8;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (IC) @(posedge clock);
    #1;
    ld_valid = 1'b1;
    ld_data  = 8'hA5;
    repeat (3) @(posedge clock);
    #1;
    check("midload_before_reset", {busy, ld_ready}, 2'b11);
    reset = 1'b0;
    #1;
    check("midload_reset_outputs",
          {tree_reset, ram_addr, ram_ena, ram_wea, ram_din, ld_ready, dbg_gnt,
           busy, done, error, err_code},
          {1'b1, 22'd0});
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (busy || ld_ready || ram_ena || ram_wea || done || error || !tree_reset) bad++;
    end
    ld_valid = 1'b0;
    check("idle_after_reset", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
